// File: rtl/dm_subword_ctrl.sv
// dm_subword_ctrl: data memory for the MEM stage with byte, halfword and word
// access, a registered read path with a valid/ready handshake, exception
// detection, and a hardware zero-fill that runs after every reset.
//
// Handshake: a request is accepted on a rising edge where req_valid and
// req_ready are both 1. Every accepted request produces exactly one response:
// rsp_valid is high for the single cycle after the accepting edge. rsp_rdata
// and rsp_exc hold their values until the next response. Requests presented
// while req_ready is 0 are dropped and produce no response.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset (restarts the zero-fill)
//   req_valid    request present
//   req_ready    block accepts requests (IDLE)
//   req_we       1 = store, 0 = load
//   req_size     0 = byte, 1 = halfword, 2 = word, 3 = illegal
//   req_unsigned loads only: 1 = zero-extend, 0 = sign-extend
//   req_addr     byte address
//   req_wdata    store data (low byte / low halfword / full word)
//   req_pc       instruction PC, used only in the store log line
//   rsp_valid    one-cycle response pulse
//   rsp_rdata    extended load data; 0 for stores and exceptions
//   rsp_exc      accepted request was misaligned, out of range or illegal size
//   busy         zero-fill in progress
module dm_subword_ctrl #(
  parameter int          DEPTH_WORDS = 3072,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter bit          LOG_EN      = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_exc,
  output logic        busy
);

  localparam int          IW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] LIMIT = 32'(4 * DEPTH_WORDS);
  localparam logic [IW-1:0] LAST_PTR = IW'(DEPTH_WORDS - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [IW-1:0] ptr;
  logic [31:0]   mem [DEPTH_WORDS];

  logic [31:0]   off;
  logic [1:0]    lane;
  logic [IW-1:0] idx;
  logic          accept;
  logic          exc;
  logic [31:0]   rd_word;
  logic [3:0]    wmask;
  logic [31:0]   wrep;
  logic [31:0]   bitmask;
  logic [31:0]   merged;
  logic [31:0]   shifted;
  logic [31:0]   ld_data;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_CLEAR;
    else       state <= state_nx;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nx = state;
    case (state)
      ST_CLEAR: if (ptr == LAST_PTR) state_nx = ST_IDLE;
      ST_IDLE:  state_nx = ST_IDLE;
      default:  state_nx = ST_CLEAR;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    req_ready = (state == ST_IDLE);
    busy      = (state == ST_CLEAR);
  end

  // Zero-fill pointer; reset mid-fill restarts from word 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  ptr <= '0;
    else if (state == ST_CLEAR) ptr <= (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
  end

  // ---------------- request decode ----------------
  // Unsigned subtraction: addresses below ADDR_BASE wrap high and fail the
  // range check below.
  assign off    = req_addr - ADDR_BASE;
  assign lane   = off[1:0];
  assign idx    = off[IW+1:2];
  assign accept = req_valid & req_ready;

  always_comb begin
    exc = 1'b0;
    if (req_size == 2'd3)                        exc = 1'b1;
    if (req_size == 2'd1 && off[0] != 1'b0)      exc = 1'b1;
    if (req_size == 2'd2 && off[1:0] != 2'b00)   exc = 1'b1;
    if (off >= LIMIT)                            exc = 1'b1;
  end

  assign rd_word = mem[idx];

  // Store lane mask and data replicated so every lane sees its bytes.
  always_comb begin
    wmask = 4'b0000;
    wrep  = req_wdata;
    case (req_size)
      2'd0: begin
        wmask = 4'b0001 << lane;
        wrep  = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        wmask = lane[1] ? 4'b1100 : 4'b0011;
        wrep  = {2{req_wdata[15:0]}};
      end
      2'd2:    wmask = 4'b1111;
      default: wmask = 4'b0000;
    endcase
  end

  assign bitmask = {{8{wmask[3]}}, {8{wmask[2]}}, {8{wmask[1]}}, {8{wmask[0]}}};
  assign merged  = (rd_word & ~bitmask) | (wrep & bitmask);

  // Load extraction: bring the addressed lane down to bit 0, then extend.
  assign shifted = rd_word >> {lane, 3'b000};

  always_comb begin
    case (req_size)
      2'd0:    ld_data = req_unsigned ? {24'h0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
      2'd1:    ld_data = req_unsigned ? {16'h0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
      default: ld_data = rd_word;
    endcase
  end

  // ---------------- array ----------------
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR)               mem[ptr] <= 32'h0;
    else if (accept && req_we && !exc)   mem[idx] <= merged;
  end

  // ---------------- response registers ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_exc   <= 1'b0;
    end else begin
      rsp_valid <= accept;
      if (accept) begin
        rsp_exc   <= exc;
        rsp_rdata <= (exc || req_we) ? 32'h0 : ld_data;
      end
    end
  end

`ifndef SYNTHESIS
  // Store trace: time, PC, word-aligned address, merged word.
  always @(posedge clk) begin
    if (LOG_EN && !reset && accept && req_we && !exc)
      $display("%d@%h: *%h <= %h", $time, req_pc, {req_addr[31:2], 2'b00}, merged);
  end
`endif

endmodule

// File: tb/tb_dm_subword_ctrl.sv
module tb_dm_subword_ctrl;

  localparam int DEPTH = 3072;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // main instance (ADDR_BASE = 0)
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata, req_pc;
  logic        rsp_valid, rsp_exc, busy;
  logic [31:0] rsp_rdata;

  // second instance (ADDR_BASE = 0x1000)
  logic        b_req_valid, b_req_ready, b_req_we, b_req_unsigned;
  logic [1:0]  b_req_size;
  logic [31:0] b_req_addr, b_req_wdata, b_req_pc;
  logic        b_rsp_valid, b_rsp_exc, b_busy;
  logic [31:0] b_rsp_rdata;

  int checks   = 0;
  int failures = 0;

  // Reference memory kept as a flat byte array indexed by byte offset.
  logic [7:0] ref_bytes [4*DEPTH];

  dm_subword_ctrl #(.DEPTH_WORDS(DEPTH), .ADDR_BASE(32'h0), .LOG_EN(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_pc(req_pc),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_exc(rsp_exc), .busy(busy)
  );

  dm_subword_ctrl #(.DEPTH_WORDS(DEPTH), .ADDR_BASE(32'h0000_1000), .LOG_EN(1'b0)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_size(b_req_size), .req_unsigned(b_req_unsigned), .req_addr(b_req_addr),
    .req_wdata(b_req_wdata), .req_pc(b_req_pc),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_exc(b_rsp_exc), .busy(b_busy)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  task automatic model_op(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic exc, output logic [31:0] data);
    int n;
    logic [31:0] v;
    n    = 1 << size;
    exc  = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
           (size == 2'd2 && addr % 4 != 0) || (addr >= 32'(4*DEPTH));
    data = 32'h0;
    if (!exc) begin
      if (we) begin
        for (int i = 0; i < n; i++) ref_bytes[addr + 32'(i)] = wdata[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_bytes[addr + 32'(i)]) << (8*i));
        if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
        data = v;
      end
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4*DEPTH; i++) ref_bytes[i] = 8'h00;
  endtask

  // ---------------- drivers (called at negedge, return at negedge) ----------------
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_pc = 32'h0000_0400 + addr;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic b_issue(input logic we, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata);
    b_req_we = we; b_req_size = size; b_req_unsigned = 1'b0;
    b_req_addr = addr; b_req_wdata = wdata; b_req_pc = 32'h0;
    b_req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_req_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int cnt;
    bit bad;
    reset = 1'b1;
    // A store held during reset and clear must be ignored.
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h10;
    req_wdata = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || req_ready !== 1'b0 || rsp_valid !== 1'b0 ||
        rsp_rdata !== 32'h0 || rsp_exc !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: busy=%b ready=%b v=%b data=%h exc=%b, want 1 0 0 0 0",
               busy, req_ready, rsp_valid, rsp_rdata, rsp_exc);
    end
    reset = 1'b0;
    cnt = 0; bad = 1'b0;
    while (busy === 1'b1 && cnt < 5000) begin
      if (req_ready !== 1'b0 || rsp_valid !== 1'b0) bad = 1'b1;
      cnt++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    model_clear();
    checks++;
    if (cnt != DEPTH) begin
      failures++;
      $display("FAIL clear_length: got %0d cycles, want %0d", cnt, DEPTH);
    end
    checks++;
    if (bad || req_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0 || b_busy !== 1'b0) begin
      failures++;
      $display("FAIL clear_flags: bad=%b ready=%b busy=%b v=%b b_busy=%b, want 0 1 0 0 0",
               bad, req_ready, busy, rsp_valid, b_busy);
    end
  endtask

  task automatic test_byte_loads();
    logic        we_t  [7] = '{1, 0, 1, 0, 0, 0, 0};
    logic [1:0]  sz_t  [7] = '{2, 0, 0, 0, 0, 1, 2};
    logic        un_t  [7] = '{0, 0, 0, 0, 1, 0, 0};
    logic [31:0] ad_t  [7] = '{32'h10, 32'h11, 32'h13, 32'h13, 32'h13, 32'h10, 32'h10};
    logic [31:0] wd_t  [7] = '{32'h1234_5678, 0, 32'h80, 0, 0, 0, 0};
    logic [31:0] ex_t  [7] = '{0, 32'h56, 0, 32'hFFFF_FF80, 32'h80, 32'h5678, 32'h8034_5678};
    logic e; logic [31:0] d;
    for (int i = 0; i < 7; i++) begin
      model_op(we_t[i], sz_t[i], un_t[i], ad_t[i], wd_t[i], e, d);
      issue(we_t[i], sz_t[i], un_t[i], ad_t[i], wd_t[i]);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_exc !== 1'b0 || rsp_rdata !== ex_t[i]) begin
        failures++;
        $display("FAIL byte_load[%0d]: got v=%b exc=%b data=%h, want v=1 exc=0 data=%h",
                 i, rsp_valid, rsp_exc, rsp_rdata, ex_t[i]);
      end
    end
  endtask

  task automatic test_halfword();
    logic        we_t [4] = '{1, 0, 0, 0};
    logic        un_t [4] = '{0, 0, 1, 0};
    logic [1:0]  sz_t [4] = '{1, 1, 1, 2};
    logic [31:0] ad_t [4] = '{32'h22, 32'h22, 32'h22, 32'h20};
    logic [31:0] ex_t [4] = '{0, 32'hFFFF_BEEF, 32'h0000_BEEF, 32'hBEEF_0000};
    logic e; logic [31:0] d;
    for (int i = 0; i < 4; i++) begin
      model_op(we_t[i], sz_t[i], un_t[i], ad_t[i], 32'h1234_BEEF, e, d);
      issue(we_t[i], sz_t[i], un_t[i], ad_t[i], 32'h1234_BEEF);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_exc !== 1'b0 || rsp_rdata !== ex_t[i]) begin
        failures++;
        $display("FAIL halfword[%0d]: got v=%b exc=%b data=%h, want v=1 exc=0 data=%h",
                 i, rsp_valid, rsp_exc, rsp_rdata, ex_t[i]);
      end
    end
  endtask

  task automatic test_exceptions();
    // Preload word 0, fire four faulting requests, then read word 0 back.
    logic        we_t [7] = '{1, 1, 0, 1, 0, 0, 0};
    logic [1:0]  sz_t [7] = '{2, 2, 1, 3, 2, 2, 0};
    logic [31:0] ad_t [7] = '{32'h0, 32'h2, 32'h1, 32'h0, 32'h3000, 32'h0, 32'h2FFF};
    logic        xe_t [7] = '{0, 1, 1, 1, 1, 0, 0};
    logic [31:0] xd_t [7] = '{0, 0, 0, 0, 0, 32'h1122_3344, 0};
    for (int i = 0; i < 7; i++) begin
      issue(we_t[i], sz_t[i], 1'b0, ad_t[i], (i == 0) ? 32'h1122_3344 : 32'hFFFF_FFFF);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_exc !== xe_t[i] || rsp_rdata !== xd_t[i]) begin
        failures++;
        $display("FAIL exception[%0d]: got v=%b exc=%b data=%h, want v=1 exc=%b data=%h",
                 i, rsp_valid, rsp_exc, rsp_rdata, xe_t[i], xd_t[i]);
      end
    end
    ref_bytes[0] = 8'h44; ref_bytes[1] = 8'h33; ref_bytes[2] = 8'h22; ref_bytes[3] = 8'h11;
  endtask

  task automatic test_back_to_back();
    logic e; logic [31:0] d;
    model_op(1'b1, 2'd0, 1'b0, 32'h40, 32'h0000_00AA, e, d);
    issue(1'b1, 2'd0, 1'b0, 32'h40, 32'h0000_00AA);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_exc !== 1'b0 || rsp_rdata !== 32'h0) begin
      failures++;
      $display("FAIL b2b_store: got v=%b exc=%b data=%h, want v=1 exc=0 data=0",
               rsp_valid, rsp_exc, rsp_rdata);
    end
    model_op(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, e, d);
    issue(1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_exc !== 1'b0 || rsp_rdata !== 32'h0000_00AA) begin
      failures++;
      $display("FAIL b2b_load: got v=%b exc=%b data=%h, want v=1 exc=0 data=000000aa",
               rsp_valid, rsp_exc, rsp_rdata);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0000_00AA || rsp_exc !== 1'b0) begin
      failures++;
      $display("FAIL b2b_hold: got v=%b exc=%b data=%h, want v=0 exc=0 data=000000aa",
               rsp_valid, rsp_exc, rsp_rdata);
    end
  endtask

  task automatic test_random();
    logic we, uns, e;
    logic [1:0] sz;
    logic [31:0] ad, wd, d;
    int bad = 0;
    for (int i = 0; i < 300; i++) begin
      we  = 1'($urandom_range(0, 1));
      sz  = 2'($urandom_range(0, 3));
      uns = 1'($urandom_range(0, 1));
      wd  = $urandom;
      if ($urandom_range(0, 7) == 0) ad = 32'($urandom_range(32'h2FF0, 32'h3010));
      else                           ad = 32'($urandom_range(0, 127));
      if ($urandom_range(0, 3) != 0 && sz != 2'd3) ad = ad & ~((32'd1 << sz) - 32'd1);
      model_op(we, sz, uns, ad, wd, e, d);
      issue(we, sz, uns, ad, wd);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_exc !== e || rsp_rdata !== d) begin
        failures++;
        if (bad++ < 10)
          $display("FAIL random[%0d] we=%b sz=%0d u=%b a=%h: got v=%b exc=%b data=%h, want v=1 exc=%b data=%h",
                   i, we, sz, uns, ad, rsp_valid, rsp_exc, rsp_rdata, e, d);
      end
      if ($urandom_range(0, 4) == 0) begin
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || rsp_exc !== e || rsp_rdata !== d) begin
          failures++;
          $display("FAIL random_hold[%0d]: got v=%b exc=%b data=%h, want v=0 exc=%b data=%h",
                   i, rsp_valid, rsp_exc, rsp_rdata, e, d);
        end
      end
    end
  endtask

  task automatic test_base_offset();
    logic        we_t [5] = '{0, 1, 0, 0, 0};
    logic [31:0] ad_t [5] = '{32'h0FFC, 32'h1004, 32'h1004, 32'h1000, 32'h4000};
    logic        xe_t [5] = '{1, 0, 0, 0, 1};
    logic [31:0] xd_t [5] = '{0, 0, 32'hCAFE_F00D, 0, 0};
    for (int i = 0; i < 5; i++) begin
      b_issue(we_t[i], 2'd2, ad_t[i], 32'hCAFE_F00D);
      checks++;
      if (b_rsp_valid !== 1'b1 || b_rsp_exc !== xe_t[i] || b_rsp_rdata !== xd_t[i]) begin
        failures++;
        $display("FAIL base_offset[%0d] a=%h: got v=%b exc=%b data=%h, want v=1 exc=%b data=%h",
                 i, ad_t[i], b_rsp_valid, b_rsp_exc, b_rsp_rdata, xe_t[i], xd_t[i]);
      end
    end
  endtask

  task automatic test_mid_clear_reset();
    int cnt;
    issue(1'b1, 2'd2, 1'b0, 32'h60, 32'hDEAD_BEEF);
    issue(1'b0, 2'd2, 1'b0, 32'h60, 32'h0);
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b1 || req_ready !== 1'b0 || rsp_valid !== 1'b0 ||
        rsp_rdata !== 32'h0 || rsp_exc !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: busy=%b ready=%b v=%b data=%h exc=%b, want 1 0 0 0 0",
               busy, req_ready, rsp_valid, rsp_rdata, rsp_exc);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 5000) begin
      cnt++;
      @(negedge clk);
    end
    checks++;
    if (cnt != DEPTH) begin
      failures++;
      $display("FAIL restart_length: got %0d cycles, want %0d", cnt, DEPTH);
    end
    model_clear();
    issue(1'b0, 2'd2, 1'b0, 32'h60, 32'h0);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_exc !== 1'b0 || rsp_rdata !== 32'h0) begin
      failures++;
      $display("FAIL cleared_word: got v=%b exc=%b data=%h, want v=1 exc=0 data=0",
               rsp_valid, rsp_exc, rsp_rdata);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; req_pc = 32'h0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_size = 2'd0; b_req_unsigned = 1'b0;
    b_req_addr = 32'h0; b_req_wdata = 32'h0; b_req_pc = 32'h0;
    reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_byte_loads();
    test_halfword();
    test_exceptions();
    test_back_to_back();
    test_random();
    test_base_offset();
    test_mid_clear_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
